lpc_host: RTL
=============

Name: lpc_host

Overview:
- LPC host (initiator) that generates LPC I/O read and I/O write cycles toward an LPC peripheral on the shared LAD/LFRAME# bus.
- A local request port issues single-byte transfers at 16-bit I/O addresses. The block sequences START, CYCTYPE, ADDR, TAR, SYNC and DATA, then returns read data and status.
- Sits at the chipset/host side of the bus; it is the test and bring-up counterpart of the LPC peripheral module.

Parameters:
- NODEV_CLKS, 3, consecutive SYNC-phase clocks of LAD=4'b1111 (or an undefined code) after which the host declares no device present.
- LWAIT_MAX, 256, maximum consecutive wait-SYNC clocks before timeout abort (used only when LPC_HOST_TIMEOUT_EN is defined).

Ports:
- clk_i  input  1  LPC clock; all logic on posedge.
- rst_i  input  1  asynchronous, active-high reset.
- req_i  input  1  transfer request; accepted when req_i && ready_o at posedge.
- we_i  input  1  1 = I/O write, 0 = I/O read; sampled on accept.
- addr_i  input  16  I/O address; sampled on accept.
- wdata_i  input  8  write data; sampled on accept.
- ready_o  output  1  high while the FSM is in IDLE.
- done_o  output  1  one-clock pulse at transaction end.
- err_o  output  1  valid with done_o: 1 = error SYNC, no device, or timeout.
- rdata_o  output  8  read data; valid with done_o and held until the next accept.
- lframe_o  output  1  LFRAME#, active low.
- lad_bus  inout  4  LAD[3:0]; driven only in the host-drive states listed below, otherwise 4'bzzzz.
- state_o  output  5  current FSM state, for debug.

Behaviour:
- Reset (async): FSM=IDLE, lframe_o=1, lad_bus released, ready_o=1, done_o=0, err_o=0, rdata_o=8'h00. Reset asserted mid-cycle takes effect immediately, with no abort sequence.
- All outputs are registered and launched at posedge. LAD input is sampled at posedge.
- Accept: on req_i && ready_o, latch we/addr/wdata. START begins the next clock.
- State sequence; the host drives LAD in the states marked "drive".
  - START: lframe_o=0, drive 4'b0000.
  - CYCTYPE: lframe_o=1, drive 4'b0010 for write or 4'b0000 for read.
  - ADDR1..ADDR4: drive addr[15:12], [11:8], [7:4], [3:0].
  - Write only, DATA_W1/DATA_W2: drive wdata[3:0], then wdata[7:4].
  - TAR1: drive 4'b1111.
  - TAR2: release LAD.
  - SYNC: release LAD and sample.
    - 4'b0000 (ready): go to the next state.
    - 4'b1010 (error): set error flag, go to the next state.
    - 4'b0101 (short wait) or 4'b0110 (long wait): stay in SYNC, clear the no-device count.
    - Any other code, including 4'b1111: increment the no-device count; on reaching NODEV_CLKS, go to ABORT.
  - Read only, DATA_R1/DATA_R2: sample rdata[3:0], then rdata[7:4].
  - FTAR1/FTAR2: LAD released; the peripheral drives 1111, then floats.
  - After FTAR2: return to IDLE, pulse done_o, assert err_o if the error flag is set.
- Zero-wait latency: 13 LPC clocks from START through FTAR2, for both read and write. done_o appears in the clock after FTAR2. ready_o is high in that same clock, so back-to-back requests are accepted with no gap.
- Each wait SYNC clock adds exactly one clock of latency.
- ABORT: lframe_o=0 and drive 4'b1111 for 4 clocks; then one clock with lframe_o=1 and LAD released; then IDLE with done_o=1, err_o=1, rdata_o=8'hFF.
- req_i is ignored while ready_o=0. No queueing.
- lad_bus is never driven in TAR2, SYNC, DATA_R*, FTAR* or IDLE.

Optional Feature:
- Macro: LPC_HOST_TIMEOUT_EN.
- Defined: a wait counter counts consecutive 0101/0110 SYNC clocks and clears on any other code. When it reaches LWAIT_MAX, the FSM enters ABORT, and the transfer ends with err_o=1.
- Not defined: wait SYNCs are honoured indefinitely. The counter logic is absent. NODEV_CLKS detection remains in both builds.

Test Plan:
- Write addr=16'h0080, wdata=8'hA5, peripheral returns SYNC 0000 -> LAD sequence 0000,0010,0,0,8,0,5,A,F,Z; done_o at accept+14 clocks; err_o=0.
- Read addr=16'h03F8, peripheral SYNC 0000 then data nibbles 4'h3,4'hC -> rdata_o=8'hC3 with done_o; err_o=0; LAD released from TAR2 onward.
- Read with 5 clocks of SYNC 0110 then 0000 -> done_o delayed by exactly 5 clocks versus the zero-wait case; data correct.
- No peripheral (LAD pulled to 1111) -> ABORT after 3 SYNC clocks; lframe_o low for 4 clocks with LAD=1111; done_o with err_o=1, rdata_o=8'hFF.
- Peripheral returns SYNC 1010 on a read -> data still sampled; done_o with err_o=1. With LPC_HOST_TIMEOUT_EN defined and LWAIT_MAX=8, 8 long-wait SYNCs -> ABORT, err_o=1.
- rst_i pulsed during ADDR2 -> lframe_o=1 and LAD high-Z immediately; ready_o=1, no done_o; the next request completes normally.

Source files
------------

// File: rtl/lpc_host.sv
// LPC host (initiator): issues single-byte LPC I/O read and I/O write cycles
// on LAD[3:0]/LFRAME# from a simple request/ready local port.
// Optional build macro LPC_HOST_TIMEOUT_EN adds a consecutive wait-SYNC
// counter that aborts the cycle after LWAIT_MAX wait clocks.
module lpc_host #(
  parameter int NODEV_CLKS = 3,
  parameter int LWAIT_MAX  = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [15:0] addr_i,
  input  logic [7:0]  wdata_i,
  output logic        ready_o,
  output logic        done_o,
  output logic        err_o,
  output logic [7:0]  rdata_o,
  output logic        lframe_o,
  inout  wire  [3:0]  lad_bus,
  output logic [4:0]  state_o
);

  localparam logic [4:0] S_IDLE      = 5'd0;
  localparam logic [4:0] S_START     = 5'd1;
  localparam logic [4:0] S_CYCTYPE   = 5'd2;
  localparam logic [4:0] S_ADDR1     = 5'd3;
  localparam logic [4:0] S_ADDR2     = 5'd4;
  localparam logic [4:0] S_ADDR3     = 5'd5;
  localparam logic [4:0] S_ADDR4     = 5'd6;
  localparam logic [4:0] S_DATA_W1   = 5'd7;
  localparam logic [4:0] S_DATA_W2   = 5'd8;
  localparam logic [4:0] S_TAR1      = 5'd9;
  localparam logic [4:0] S_TAR2      = 5'd10;
  localparam logic [4:0] S_SYNC      = 5'd11;
  localparam logic [4:0] S_DATA_R1   = 5'd12;
  localparam logic [4:0] S_DATA_R2   = 5'd13;
  localparam logic [4:0] S_FTAR1     = 5'd14;
  localparam logic [4:0] S_FTAR2     = 5'd15;
  localparam logic [4:0] S_ABORT     = 5'd16;
  localparam logic [4:0] S_ABORT_END = 5'd17;

  localparam int NODEV_W = $clog2(NODEV_CLKS + 1);

  logic [4:0]         state;
  logic [4:0]         state_nxt;
  logic               we_q;
  logic [15:0]        addr_q;
  logic [7:0]         wdata_q;
  logic [7:0]         rdata_q;
  logic               err_flag;
  logic [NODEV_W-1:0] nodev_cnt;
  logic [1:0]         abort_cnt;
  logic               lad_oe;
  logic [3:0]         lad_do;

  logic               accept;
  logic               sync_ok;
  logic               sync_err;
  logic               sync_wait;
  logic               nodev_hit;
  logic               timeout_hit;
  logic               we_n;
  logic [15:0]        addr_n;
  logic [7:0]         wdata_n;

  // Nibble the host places on LAD while in a given state.
  function automatic logic [3:0] lad_nibble(input logic [4:0]  st,
                                            input logic        we,
                                            input logic [15:0] a,
                                            input logic [7:0]  wd);
    case (st)
      S_CYCTYPE:      return we ? 4'b0010 : 4'b0000;
      S_ADDR1:        return a[15:12];
      S_ADDR2:        return a[11:8];
      S_ADDR3:        return a[7:4];
      S_ADDR4:        return a[3:0];
      S_DATA_W1:      return wd[3:0];
      S_DATA_W2:      return wd[7:4];
      S_TAR1, S_ABORT: return 4'b1111;
      default:        return 4'b0000;
    endcase
  endfunction

  // States in which the host owns LAD.
  function automatic logic lad_drives(input logic [4:0] st);
    case (st)
      S_START, S_CYCTYPE, S_ADDR1, S_ADDR2, S_ADDR3, S_ADDR4,
      S_DATA_W1, S_DATA_W2, S_TAR1, S_ABORT: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

  assign accept    = req_i && ready_o;
  assign lad_bus   = lad_oe ? lad_do : 4'bzzzz;
  assign state_o   = state;

  // The cycle that accepts a request already launches START, so the
  // drive value must come from the request port rather than the latches.
  assign we_n      = accept ? we_i    : we_q;
  assign addr_n    = accept ? addr_i  : addr_q;
  assign wdata_n   = accept ? wdata_i : wdata_q;

  assign sync_ok   = (lad_bus == 4'b0000);
  assign sync_err  = (lad_bus == 4'b1010);
  assign sync_wait = (lad_bus == 4'b0101) || (lad_bus == 4'b0110);
  assign nodev_hit = (state == S_SYNC) && !sync_ok && !sync_err && !sync_wait &&
                     (nodev_cnt == NODEV_W'(NODEV_CLKS - 1));

`ifdef LPC_HOST_TIMEOUT_EN
  localparam int WAIT_W = $clog2(LWAIT_MAX + 1);
  logic [WAIT_W-1:0] wait_cnt;

  // Count consecutive wait SYNCs; any other code or a new transfer restarts it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt <= '0;
    end else if (accept) begin
      wait_cnt <= '0;
    end else if (state == S_SYNC) begin
      wait_cnt <= sync_wait ? wait_cnt + 1'b1 : '0;
    end
  end

  assign timeout_hit = (state == S_SYNC) && sync_wait &&
                       (wait_cnt == WAIT_W'(LWAIT_MAX - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state sequencing of the LPC I/O cycle
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (accept) state_nxt = S_START;
      S_START:     state_nxt = S_CYCTYPE;
      S_CYCTYPE:   state_nxt = S_ADDR1;
      S_ADDR1:     state_nxt = S_ADDR2;
      S_ADDR2:     state_nxt = S_ADDR3;
      S_ADDR3:     state_nxt = S_ADDR4;
      S_ADDR4:     state_nxt = we_q ? S_DATA_W1 : S_TAR1;
      S_DATA_W1:   state_nxt = S_DATA_W2;
      S_DATA_W2:   state_nxt = S_TAR1;
      S_TAR1:      state_nxt = S_TAR2;
      S_TAR2:      state_nxt = S_SYNC;
      S_SYNC: begin
        if (sync_ok || sync_err)       state_nxt = we_q ? S_FTAR1 : S_DATA_R1;
        else if (timeout_hit)          state_nxt = S_ABORT;
        else if (nodev_hit)            state_nxt = S_ABORT;
      end
      S_DATA_R1:   state_nxt = S_DATA_R2;
      S_DATA_R2:   state_nxt = S_FTAR1;
      S_FTAR1:     state_nxt = S_FTAR2;
      S_FTAR2:     state_nxt = S_IDLE;
      S_ABORT:     if (abort_cnt == 2'd3) state_nxt = S_ABORT_END;
      S_ABORT_END: state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Control state, registered bus drive and completion status
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      ready_o   <= 1'b1;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      rdata_o   <= 8'h00;
      lframe_o  <= 1'b1;
      lad_oe    <= 1'b0;
      lad_do    <= 4'b0000;
      err_flag  <= 1'b0;
      nodev_cnt <= '0;
      abort_cnt <= 2'd0;
    end else begin
      state    <= state_nxt;
      ready_o  <= (state_nxt == S_IDLE);
      lframe_o <= !((state_nxt == S_START) || (state_nxt == S_ABORT));
      lad_oe   <= lad_drives(state_nxt);
      lad_do   <= lad_nibble(state_nxt, we_n, addr_n, wdata_n);
      done_o   <= (state == S_FTAR2) || (state == S_ABORT_END);
      err_o    <= ((state == S_FTAR2) && err_flag) || (state == S_ABORT_END);

      if ((state == S_FTAR2) && !we_q) begin
        rdata_o <= rdata_q;
      end else if (state == S_ABORT_END) begin
        rdata_o <= 8'hFF;
      end

      if (accept) begin
        err_flag <= 1'b0;
      end else if ((state == S_SYNC) && sync_err) begin
        err_flag <= 1'b1;
      end

      if (accept) begin
        nodev_cnt <= '0;
      end else if (state == S_SYNC) begin
        if (sync_wait) begin
          nodev_cnt <= '0;
        end else if (!sync_ok && !sync_err) begin
          nodev_cnt <= nodev_cnt + 1'b1;
        end
      end

      abort_cnt <= (state == S_ABORT) ? abort_cnt + 2'd1 : 2'd0;
    end
  end

  // Request latches and read-data nibble capture
  always_ff @(posedge clk_i) begin
    if (accept) begin
      we_q    <= we_i;
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
    end
    if (state == S_DATA_R1) begin
      rdata_q[3:0] <= lad_bus;
    end
    if (state == S_DATA_R2) begin
      rdata_q[7:4] <= lad_bus;
    end
  end

endmodule
